mem_sequencer: RTL and testbench

Multicycle sequencer that lets the single-cycle CPU datapath share one single-ported memory between instruction fetch and load/store. It fetches the instruction at `pc` into a holding register and lets the datapath decode it. For loads and stores it runs a second memory transaction and latches the read data. It then issues a one-cycle `commit` strobe that enables the PC register and gates `regwrite`. It sits between the datapath/control unit and the memory model, with a watchdog on the memory handshake.

---
 rtl/mem_sequencer_pkg.sv | 25 ++
 rtl/mem_sequencer_ack_timer.sv | 48 ++++
 rtl/mem_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mem_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared types for the memory sequencer: controller state encoding and the
// default handshake watchdog limit.
package memseq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Counter width able to hold 0..timeout-1; at least one bit so a disabled
  // watchdog still elaborates.
  function automatic int timer_width(input int timeout);
    if (timeout > 1) begin
      return $clog2(timeout);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_sequencer_ack_timer.sv
// Watchdog for the memory handshake: counts unacknowledged request cycles and
// flags the cycle in which the count would reach TIMEOUT.
module ack_timer
  import memseq_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = timer_width(TIMEOUT);
  localparam logic ARMED = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: cleared outside request states, holds once at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CW{1'b0}};
    end else if (enable_i && ARMED && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Expiry is combinational so a same-cycle ack can still take priority.
  always_comb begin
    expired_o = ARMED && enable_i && (count_q == LAST);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Multicycle sequencer sharing one single-ported memory between instruction
// fetch and load/store, with a one-cycle retire strobe and handshake watchdog.
module mem_sequencer
  import memseq_pkg::*;
#(
  parameter int n       = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] pc,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [n-1:0] daddr,
  input  logic [n-1:0] dwdata,
  output logic [n-1:0] instr,
  output logic [n-1:0] readdata,
  output logic         commit,
  output logic         m_req,
  output logic         m_we,
  output logic [n-1:0] m_addr,
  output logic [n-1:0] m_wdata,
  input  logic [n-1:0] m_rdata,
  input  logic         m_ack,
  output logic         err,
  output logic [n-1:0] retired
);

  state_e       state_q, state_d;
  logic [n-1:0] instr_q, instr_d;
  logic [n-1:0] readdata_q, readdata_d;
  logic [n-1:0] req_addr_q, req_addr_d;
  logic [n-1:0] req_wdata_q, req_wdata_d;
  logic         req_we_q, req_we_d;
  logic [n-1:0] retired_q, retired_d;

  logic         req_s;
  logic         we_s;
  logic [n-1:0] addr_s;
  logic         commit_s;
  logic         expired_s;
  logic         timer_clear_s;
  logic         timer_enable_s;

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timer_clear_s),
    .enable_i  (timer_enable_s),
    .expired_o (expired_s)
  );

  // Next-state, bus and capture decode; ack is only honoured in request states.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    readdata_d  = readdata_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    req_s       = 1'b0;
    we_s        = 1'b0;
    addr_s      = pc;
    commit_s    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        req_s  = 1'b1;
        addr_s = pc;
        if (m_ack) begin
          instr_d = m_rdata;
          state_d = ST_EXEC;
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (memread || memwrite) begin
          req_addr_d  = daddr;
          req_wdata_d = dwdata;
          req_we_d    = memwrite;
          state_d     = ST_MEM;
        end else begin
          commit_s = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_MEM: begin
        req_s  = 1'b1;
        we_s   = req_we_q;
        addr_s = req_addr_q;
        if (m_ack) begin
          if (!req_we_q) begin
            readdata_d = m_rdata;
          end else begin
            readdata_d = readdata_q;
          end
          state_d = ST_WB;
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        commit_s = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held so nothing leaks mid-reset.
  always_comb begin
    m_req   = req_s & ~reset;
    commit  = commit_s & ~reset;
    m_we    = we_s & ~reset;
    m_addr  = addr_s;
    m_wdata = req_wdata_q;
  end

  // Watchdog control and retire counter next value.
  always_comb begin
    timer_clear_s  = (state_q != ST_FETCH) && (state_q != ST_MEM);
    timer_enable_s = m_req & ~m_ack;
    if (commit) begin
      retired_d = retired_q + n'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State and datapath-facing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      instr_q     <= {n{1'b0}};
      readdata_q  <= {n{1'b0}};
      req_addr_q  <= {n{1'b0}};
      req_wdata_q <= {n{1'b0}};
      req_we_q    <= 1'b0;
      retired_q   <= {n{1'b0}};
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      readdata_q  <= readdata_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      retired_q   <= retired_d;
    end
  end

  // Register-backed outputs.
  always_comb begin
    instr    = instr_q;
    readdata = readdata_q;
    retired  = retired_q;
    err      = (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction transaction model.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, daddr, dwdata, m_rdata;
  logic        memread, memwrite, m_ack;
  logic [31:0] instr, readdata, m_addr, m_wdata, retired;
  logic        commit, m_req, m_we, err;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_instr, exp_rdata, exp_retired;

  mem_sequencer #(.n(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .memread(memread), .memwrite(memwrite),
    .daddr(daddr), .dwdata(dwdata), .instr(instr), .readdata(readdata),
    .commit(commit), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Every task is entered at a falling edge: drive, settle, check, advance.
  task automatic test_reset();
    reset = 1'b1; m_ack = 1'b1; m_rdata = $urandom;
    #1;
    checks++;
    if ({m_req, commit} !== 2'b00) begin
      fails++; $display("FAIL reset_strobes: got req/commit %b expected 00", {m_req, commit});
    end
    @(negedge clk);
    m_rdata = $urandom;
    #1;
    checks++;
    if ({m_req, commit, err, instr, readdata, retired} !== {3'b000, 96'h0}) begin
      fails++;
      $display("FAIL reset_state: got req=%b commit=%b err=%b instr=%h rd=%h ret=%0d expected all zero",
               m_req, commit, err, instr, readdata, retired);
    end
    @(negedge clk);
    reset = 1'b0; m_ack = 1'b0;
    exp_instr = 32'h0; exp_rdata = 32'h0; exp_retired = 32'h0;
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store, 3 = memread and memwrite (store).
  task automatic run_instr(input logic [31:0] pc_v, input int kind, input int fw, input int dw,
                           input logic [31:0] ins_v, input logic [31:0] da_v,
                           input logic [31:0] dd_v, input logic [31:0] ld_v);
    logic mem_op, st;
    mem_op = (kind != 0);
    st     = (kind >= 2);
    for (int c = 0; c <= fw; c++) begin
      pc = pc_v; memread = $urandom; memwrite = $urandom; daddr = $urandom; dwdata = $urandom;
      m_ack = (c == fw); m_rdata = (c == fw) ? ins_v : $urandom;
      #1;
      checks++;
      if ({m_req, m_we, commit, err, m_addr} !== {4'b1000, pc_v}) begin
        fails++;
        $display("FAIL fetch_bus: got req=%b we=%b commit=%b err=%b addr=%h expected 1000 addr=%h",
                 m_req, m_we, commit, err, m_addr, pc_v);
      end
      checks++;
      if ({instr, readdata, retired} !== {exp_instr, exp_rdata, exp_retired}) begin
        fails++;
        $display("FAIL fetch_hold: got instr=%h rd=%h ret=%0d expected instr=%h rd=%h ret=%0d",
                 instr, readdata, retired, exp_instr, exp_rdata, exp_retired);
      end
      @(negedge clk);
    end
    exp_instr = ins_v;
    memread = (kind == 1) || (kind == 3); memwrite = st; daddr = da_v; dwdata = dd_v;
    m_ack = 1'b1; m_rdata = $urandom;
    #1;
    checks++;
    if ({m_req, commit, err, instr} !== {1'b0, !mem_op, 1'b0, ins_v}) begin
      fails++;
      $display("FAIL exec: got req=%b commit=%b err=%b instr=%h expected req=0 commit=%b err=0 instr=%h",
               m_req, commit, err, instr, !mem_op, ins_v);
    end
    @(negedge clk);
    if (!mem_op) begin
      exp_retired++;
    end else begin
      for (int c = 0; c <= dw; c++) begin
        memread = $urandom; memwrite = $urandom; daddr = $urandom; dwdata = $urandom;
        m_ack = (c == dw); m_rdata = (c == dw) ? ld_v : $urandom;
        #1;
        checks++;
        if ({m_req, m_we, commit, m_addr, m_wdata, readdata} !== {1'b1, st, 1'b0, da_v, dd_v, exp_rdata}) begin
          fails++;
          $display("FAIL mem_bus: got req=%b we=%b commit=%b addr=%h wd=%h rd=%h expected 1 %b 0 %h %h %h",
                   m_req, m_we, commit, m_addr, m_wdata, readdata, st, da_v, dd_v, exp_rdata);
        end
        @(negedge clk);
      end
      if (kind == 1) exp_rdata = ld_v;
      m_ack = 1'b1; m_rdata = $urandom;
      #1;
      checks++;
      if ({m_req, commit, err, readdata, instr} !== {3'b010, exp_rdata, exp_instr}) begin
        fails++;
        $display("FAIL writeback: got req=%b commit=%b err=%b rd=%h instr=%h expected 010 rd=%h instr=%h",
                 m_req, commit, err, readdata, instr, exp_rdata, exp_instr);
      end
      @(negedge clk);
      exp_retired++;
    end
  endtask

  task automatic test_alu_zero_wait();
    run_instr(32'h0, 0, 0, 0, 32'h0022_0820, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_load_store();
    run_instr(32'h4, 1, 0, 3, 32'h8C22_0010, 32'h10, 32'h0, 32'hCAFE_F00D);
    run_instr(32'h8, 2, 0, 2, 32'hAC03_0040, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678);
    run_instr(32'hC, 3, 1, 1, 32'hAC04_0044, 32'h44, 32'h0BAD_F00D, 32'h8765_4321);
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 40; i++) begin
      run_instr({$urandom_range(0, 1023), 2'b00}, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom);
    end
  endtask

  task automatic test_retired_count();
    m_ack = 1'b0;
    #1;
    checks++;
    if ({retired, instr, readdata} !== {exp_retired, exp_instr, exp_rdata}) begin
      fails++;
      $display("FAIL retired_count: got ret=%0d instr=%h rd=%h expected ret=%0d instr=%h rd=%h",
               retired, instr, readdata, exp_retired, exp_instr, exp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    m_ack = 1'b1; m_rdata = 32'h8C01_0004;
    @(negedge clk);
    m_ack = 1'b0; memread = 1'b1; memwrite = 1'b0; daddr = 32'h80;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      m_ack = 1'b0;
      #1;
      checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h80}) begin
        fails++; $display("FAIL mid_mem_wait: got req=%b addr=%h expected 1 00000080", m_req, m_addr);
      end
      @(negedge clk);
    end
    test_reset();
    run_instr(32'h200, 0, 1, 0, 32'h0000_0000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    pc = 32'h100;
    for (int c = 0; c < 4; c++) begin
      m_ack = 1'b0;
      #1;
      checks++;
      if ({m_req, err} !== 2'b10) begin
        fails++; $display("FAIL timeout_wait: cycle %0d got req/err %b expected 10", c, {m_req, err});
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      m_ack = $urandom; m_rdata = $urandom;
      #1;
      checks++;
      if ({m_req, commit, err, retired} !== {3'b001, exp_retired}) begin
        fails++;
        $display("FAIL timeout_err: got req=%b commit=%b err=%b ret=%0d expected 001 ret=%0d",
                 m_req, commit, err, retired, exp_retired);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ack_on_expiry();
    run_instr(32'h300, 1, 3, 3, 32'h8C05_0008, 32'h88, 32'h0, 32'hA5A5_5A5A);
    run_instr(32'h304, 2, 3, 3, 32'hAC06_000C, 32'h8C, 32'h5555_AAAA, 32'h0);
    test_retired_count();
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; memread = 1'b0; memwrite = 1'b0;
    daddr = 32'h0; dwdata = 32'h0; m_rdata = 32'h0; m_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_zero_wait();
    test_load_store();
    test_random_stream();
    test_retired_count();
    test_reset_mid_mem();
    test_timeout();
    test_reset();
    test_ack_on_expiry();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
